// File: rtl/op_buf_pkg.sv
// op_buf_pkg: shared sizes, operand type and command encoding for the operand history buffer
package op_buf_pkg;
  localparam int OP_WIDTH = 9;
  localparam int OP_DEPTH = 4;
  typedef logic [OP_WIDTH-1:0] operand_t;
  typedef enum logic [2:0] {CMD_IDLE, CMD_CLEAR, CMD_PUSH, CMD_POP, CMD_REPLACE} buf_cmd_e;
endpackage

// File: rtl/req_edge_detect.sv
// req_edge_detect: single-bit rising-edge detector so a held request acts only once
module req_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic req,
  output logic rise
);
  logic req_d, req_q;
  always_comb req_d = req;
  always_ff @(posedge clk) begin
    if (!nrst) req_q <= 1'b0;
    else req_q <= req_d;
  end
  assign rise = req & ~req_q;
endmodule

// File: rtl/operand_history_buffer.sv
// operand_history_buffer: LIFO history of entered operands with undo/recall and occupancy status
module operand_history_buffer
  import op_buf_pkg::*;
#(
  parameter int WIDTH = OP_WIDTH,
  parameter int DEPTH = OP_DEPTH
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [WIDTH-1:0]           op_in,
  input  logic                       enter,
  input  logic                       recall,
  input  logic                       clear,
  output logic [WIDTH-1:0]           op_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       dropped,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic push, pop;
  buf_cmd_e cmd;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] top_q, top_d, top_inc, top_dec;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] op_last_q, op_last_d;
  logic dropped_q, dropped_d, underflow_q, underflow_d;
  req_edge_detect u_enter (.clk(clk), .nrst(nrst), .req(enter), .rise(push));
  req_edge_detect u_recall (.clk(clk), .nrst(nrst), .req(recall), .rise(pop));
  assign top_inc = top_q + 1'b1;
  assign top_dec = top_q - 1'b1;
  // replacing into an empty history degenerates to a plain push
  always_comb
    cmd = clear ? CMD_CLEAR :
          (push && pop) ? ((count_q != '0) ? CMD_REPLACE : CMD_PUSH) :
          push ? CMD_PUSH :
          pop ? CMD_POP : CMD_IDLE;
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    count_d = count_q;
    op_last_d = op_last_q;
    dropped_d = 1'b0;
    underflow_d = 1'b0;
    case (cmd)
      CMD_CLEAR: begin
        top_d = '0;
        count_d = '0;
        op_last_d = '0;
      end
      CMD_PUSH: begin
        top_d = top_inc;
        mem_d[top_inc] = op_in;
        op_last_d = op_in;
        count_d = (count_q == FULL_CNT) ? count_q : count_q + 1'b1;
        dropped_d = (count_q == FULL_CNT);
      end
      CMD_REPLACE: begin
        mem_d[top_q] = op_in;
        op_last_d = op_in;
      end
      CMD_POP: begin
        if (count_q == '0) underflow_d = 1'b1;
        else begin
          top_d = top_dec;
          count_d = count_q - 1'b1;
          op_last_d = (count_q == CW'(1)) ? '0 : mem_q[top_dec];
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      top_q <= '0;
      count_q <= '0;
      op_last_q <= '0;
      dropped_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q <= top_d;
      count_q <= count_d;
      op_last_q <= op_last_d;
      dropped_q <= dropped_d;
      underflow_q <= underflow_d;
    end
  end
  // storage needs no reset: invisible until written behind count
  always_ff @(posedge clk) mem_q <= mem_d;
  assign op_last = op_last_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full = (count_q == FULL_CNT);
  assign dropped = dropped_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_operand_history_buffer.sv
// tb_operand_history_buffer: directed vectors with hand-computed expectations for the history buffer
module tb_operand_history_buffer;
  logic clk = 1'b0;
  logic nrst;
  logic [8:0] op_in;
  logic enter, recall, clear;
  logic [8:0] op_last;
  logic [2:0] count;
  logic empty, full, dropped, underflow;
  int nvec = 0;
  int nerr = 0;
  operand_history_buffer dut (
    .clk(clk), .nrst(nrst), .op_in(op_in), .enter(enter), .recall(recall), .clear(clear),
    .op_last(op_last), .count(count), .empty(empty), .full(full),
    .dropped(dropped), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [8:0] v);
    op_in = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask
  task automatic pop_chk(input string tag, input logic [8:0] exp_last, input logic [2:0] exp_cnt);
    recall = 1'b1;
    tick();
    chk({tag, "_last"}, 32'(op_last), 32'(exp_last));
    chk({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
    recall = 1'b0;
    tick();
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask
  initial begin
    nrst = 1'b0; enter = 1'b1; recall = 1'b0; clear = 1'b0; op_in = 9'h1F2;
    tick(); tick();
    chk("rst_last", 32'(op_last), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pulses", {30'd0, dropped, underflow}, 0);
    nrst = 1'b1;
    tick();
    chk("rel_push_last", 32'(op_last), 32'h1F2);
    chk("rel_push_cnt", 32'(count), 1);
    enter = 1'b0;
    tick();
    do_clear();
    chk("clr_cnt", 32'(count), 0);
    push(9'h001); push(9'h002); push(9'h003); push(9'h004);
    chk("fill_last", 32'(op_last), 32'h004);
    chk("fill_cnt", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    op_in = 9'h005; enter = 1'b1;
    tick();
    chk("drop_pulse", 32'(dropped), 1);
    chk("drop_cnt", 32'(count), 4);
    chk("drop_last", 32'(op_last), 32'h005);
    enter = 1'b0;
    tick();
    chk("drop_gone", 32'(dropped), 0);
    pop_chk("pop1", 9'h004, 3'd3);
    pop_chk("pop2", 9'h003, 3'd2);
    pop_chk("pop3", 9'h002, 3'd1);
    pop_chk("pop4", 9'h000, 3'd0);
    chk("pop4_empty", 32'(empty), 1);
    chk("pop4_noundf", 32'(underflow), 0);
    op_in = 9'h0AA; enter = 1'b1;
    repeat (5) tick();
    enter = 1'b0;
    tick();
    chk("hold_cnt", 32'(count), 1);
    chk("hold_last", 32'(op_last), 32'h0AA);
    do_clear();
    recall = 1'b1;
    tick();
    chk("undf_pulse", 32'(underflow), 1);
    chk("undf_cnt", 32'(count), 0);
    chk("undf_last", 32'(op_last), 0);
    recall = 1'b0;
    tick();
    chk("undf_gone", 32'(underflow), 0);
    push(9'h011); push(9'h022);
    op_in = 9'h033; enter = 1'b1; recall = 1'b1;
    tick();
    chk("repl_last", 32'(op_last), 32'h033);
    chk("repl_cnt", 32'(count), 2);
    enter = 1'b0; recall = 1'b0;
    tick();
    pop_chk("repl_pop", 9'h011, 3'd1);
    push(9'h044); push(9'h055);
    chk("pre_clr_cnt", 32'(count), 3);
    op_in = 9'h066; clear = 1'b1; enter = 1'b1;
    tick();
    chk("clr_en_cnt", 32'(count), 0);
    chk("clr_en_last", 32'(op_last), 0);
    chk("clr_en_empty", 32'(empty), 1);
    chk("clr_en_drop", 32'(dropped), 0);
    clear = 1'b0; enter = 1'b0;
    tick();
    chk("clr_after_cnt", 32'(count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/operand_history_buffer.md
# operand_history_buffer

Parametrised operand store for the calculator datapath. It keeps the last DEPTH entered operands in a LIFO history instead of a single register. Each rising edge of `enter` pushes `op_in`. Each rising edge of `recall` pops the newest entry, giving undo/recall. The block sits between the keypad/operand-entry logic and the ALU operand muxes, and exposes the newest entry as `op_last` along with occupancy status.

## Interface
- `WIDTH`, 9, operand width in bits
- `DEPTH`, 4, number of history entries (≥2, power of two)
- `clk`  in  1  system clock, rising-edge
- `nrst`  in  1  reset, synchronous, active-low
- `op_in`  in  WIDTH  operand to store
- `enter`  in  1  push request (level input, rising edge acted on)
- `recall`  in  1  pop request (level input, rising edge acted on)
- `clear`  in  1  empty the history (level, acted on every cycle high)
- `op_last`  out  WIDTH  newest stored operand; 0 when empty
- `count`  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `dropped`  out  1  one-cycle pulse: oldest entry discarded by a push while full
- `underflow`  out  1  one-cycle pulse: recall while empty

## Operation
- Storage: DEPTH×WIDTH circular array, `top` pointer (log2 DEPTH bits), `count` register.
- Edge detect: registers `enter_q`, `recall_q`; `push = enter & ~enter_q`, `pop = recall & ~recall_q`. Holding a request high acts once.
- Priority per cycle: `clear` > (push & pop) > push > pop > idle.
- clear: count←0, top←0, array contents left as-is but not visible; op_last←0; no pulses.
- push, not full: top←top+1 (mod DEPTH), mem[top+1]←op_in, count+1.
- push, full: same pointer/write; the overwritten slot is the oldest entry; count stays DEPTH; `dropped`←1.
- pop, count>0: top←top−1 (mod DEPTH), count−1; op_last←mem[top−1], or 0 if count becomes 0.
- pop, empty: no state change; `underflow`←1.
- push & pop same cycle: replace newest. If count>0, mem[top]←op_in, count unchanged. If empty, behave as plain push.
- op_last always equals the newest valid entry, registered. Never X, never a stale value after empty.
- Arithmetic: pointers wrap modulo DEPTH. count saturates at DEPTH and never goes below 0.

## Timing
- All outputs registered. Effect visible one cycle after the rising edge on which the request is sampled high with its `_q` low.
- `dropped` and `underflow` are high for exactly one cycle after the triggering edge, then return to 0.
- Reset, when nrst is low at a rising edge: op_last=0, count=0, empty=1, full=0, dropped=0, underflow=0, top=0, enter_q=0, recall_q=0.
- Reset mid-operation discards all history in the same edge. If `enter` is high at the first edge after release, it counts as a rising edge and is pushed.
- Back-to-back pushes need `enter` low for ≥1 cycle between them. Maximum throughput is one operation per 2 cycles per request line.

## Structure
- Package `op_buf_pkg`: `OP_WIDTH=9`, `OP_DEPTH=4`, typedef `operand_t` (logic [OP_WIDTH-1:0]), typedef `buf_cmd_e` {CMD_IDLE, CMD_CLEAR, CMD_PUSH, CMD_POP, CMD_REPLACE}.
- Sub-module `req_edge_detect`: 1-bit rising-edge detector with synchronous active-low reset, instantiated for `enter` and `recall`.
- Top level: command decode (priority encode into `buf_cmd_e`), pointer/count update, storage array, output register.

## Test plan
- Reset with enter=1, op_in=9'h1F2 held → after reset op_last=0, count=0, empty=1. One push occurs on the first edge after release, then op_last=9'h1F2, count=1.
- Push 9'h001, 9'h002, 9'h003, 9'h004 (enter pulsed) → op_last=9'h004, count=4, full=1. Push 9'h005 → dropped pulses once, count=4. Four pops yield op_last 9'h004, 9'h003, 9'h002, then 0 with empty=1.
- Hold enter high for 5 cycles with op_in=9'h0AA → exactly one push, count=1.
- Empty buffer, pulse recall → underflow high for one cycle, count=0, op_last=0.
- count=2 (9'h011, 9'h022), pulse enter and recall together with op_in=9'h033 → op_last=9'h033, count=2. Then pop → op_last=9'h011.
- count=3, assert clear together with enter → count=0, op_last=0, empty=1, no dropped pulse.
